// File: rtl/dmem_pkg.sv
// Shared types and pure helpers for the data_memory_lsu block.
// Contents:
//   load_funct3_t  - RV32I load funct3 encodings (LB, LH, LW, LBU, LHU)
//   SB/SH/SW       - store funct3 encodings (same values as LB/LH/LW)
//   access_size_t  - byte / halfword / word
//   fsm_state_t    - IDLE, SECOND (SECOND only reached with DMEM_MISALIGN_SPLIT_EN)
//   pipe_entry_t   - one stage of the response pipeline
//   size_of, span_m1, gen_be, is_legal - decode helpers
package dmem_pkg;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LBU = 3'd4,
        LHU = 3'd5
    } load_funct3_t;

    localparam logic [2:0] SB = 3'd0;
    localparam logic [2:0] SH = 3'd1;
    localparam logic [2:0] SW = 3'd2;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } access_size_t;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } fsm_state_t;

    // data holds {upper word, lower word}; the upper word is only non-zero
    // for a split access.
    typedef struct packed {
        logic        valid;
        logic        fault;
        logic        we;
        logic [2:0]  funct3;
        logic [1:0]  off;
        logic [63:0] data;
    } pipe_entry_t;

    // Access size from funct3; bit 2 only selects zero extension.
    function automatic access_size_t size_of(input logic [2:0] f3);
        access_size_t sz;
        case (f3[1:0])
            2'd0:    sz = SZ_BYTE;
            2'd1:    sz = SZ_HALF;
            default: sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    // Access size in bytes minus one.
    function automatic logic [1:0] span_m1(input access_size_t sz);
        logic [1:0] s;
        case (sz)
            SZ_BYTE: s = 2'd0;
            SZ_HALF: s = 2'd1;
            SZ_WORD: s = 2'd3;
            default: s = 2'd0;
        endcase
        return s;
    endfunction

    // Byte enables over two consecutive words: [3:0] lower word, [7:4] upper.
    function automatic logic [7:0] gen_be(input access_size_t sz, input logic [1:0] off);
        logic [7:0] mask;
        case (sz)
            SZ_BYTE: mask = 8'b0000_0001;
            SZ_HALF: mask = 8'b0000_0011;
            SZ_WORD: mask = 8'b0000_1111;
            default: mask = 8'b0000_0000;
        endcase
        return mask << off;
    endfunction

    // Loads accept 0,1,2,4,5; stores accept 0,1,2.
    function automatic logic is_legal(input logic we, input logic [2:0] f3);
        logic ok;
        case (f3)
            3'd0, 3'd1, 3'd2: ok = 1'b1;
            3'd4, 3'd5:       ok = ~we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Lane select and sign/zero extension for load data.
// Ports:
//   funct3 - load funct3 of the response
//   off    - byte offset of the access within the lower word
//   data   - {upper word, lower word}; upper only matters for split loads
//   rdata  - extended load result (0 for non-load funct3)
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [63:0] data,
    output logic [31:0] rdata
);

    logic [31:0] shifted_s;

    // Bring the addressed byte to lane 0; a split access pulls bytes from the upper word.
    assign shifted_s = 32'(data >> {off, 3'b000});

    // Extend the selected byte/halfword according to funct3.
    always_comb begin
        rdata = 32'h0000_0000;
        case (funct3)
            LB:      rdata = {{24{shifted_s[7]}}, shifted_s[7:0]};
            LH:      rdata = {{16{shifted_s[15]}}, shifted_s[15:0]};
            LW:      rdata = shifted_s;
            LBU:     rdata = {24'h00_0000, shifted_s[7:0]};
            LHU:     rdata = {16'h0000, shifted_s[15:0]};
            default: rdata = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/data_memory_lsu.sv
// RV32I data memory with a valid/ready request port and a fixed-latency
// response pipeline. Byte/half/word loads and stores, sign/zero extended loads,
// faults for out-of-range, misaligned and illegal accesses.
// Optional macro DMEM_MISALIGN_SPLIT_EN: in-range misaligned accesses are split
// over two consecutive words using a one-cycle SECOND state.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   req_valid/ready   - request handshake (accept on valid && ready)
//   req_we            - 1 = store, 0 = load
//   req_funct3        - RV32I load/store funct3
//   req_addr          - byte address
//   req_wdata         - store data, LSB aligned
//   rsp_valid         - one-cycle response strobe, RD_LATENCY cycles after accept
//   rsp_rdata         - extended load data; 0 for stores and faults
//   rsp_fault         - access faulted; memory unchanged
module data_memory_lsu
    import dmem_pkg::*;
#(
    parameter int          ADDR_WIDTH = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          RD_LATENCY = 1
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int WORDS = 2 ** IDX_W;

    logic [31:0]  mem_r [WORDS];

    fsm_state_t   state_r;
    logic         ready_r;

    logic [31:0]  off_s;
    access_size_t size_s;
    logic [7:0]   be8_s;
    logic [32:0]  end_s;
    logic         in_range_s;
    logic         legal_s;
    logic         misalign_s;
    logic         fault_s;
    logic         accept_s;
    logic [IDX_W-1:0] idx_s;

    logic             wr_en_s;
    logic [IDX_W-1:0] wr_idx_s;
    logic [3:0]       wr_be_s;
    logic [31:0]      wr_data_s;

    pipe_entry_t  push_s;
    pipe_entry_t  pipe_r [RD_LATENCY];
    pipe_entry_t  last_s;
    logic [31:0]  align_s;

    logic         rsp_valid_r;
    logic         rsp_fault_r;
    logic [31:0]  rsp_rdata_r;

`ifdef DMEM_MISALIGN_SPLIT_EN
    logic             split_s;
    logic [63:0]      wide_wdata_s;
    logic [IDX_W-1:0] hi_idx_s;
    logic             sp_we_r;
    logic [IDX_W-1:0] sp_idx_r;
    logic [3:0]       sp_be_hi_r;
    logic [31:0]      sp_data_hi_r;
    logic [31:0]      sp_lo_r;
    logic [2:0]       sp_funct3_r;
    logic [1:0]       sp_off_r;

    assign hi_idx_s = sp_idx_r + IDX_W'(1);
`endif

    assign req_ready = ready_r & ~rst;
    assign accept_s  = req_valid & req_ready;
    assign rsp_valid = rsp_valid_r;
    assign rsp_fault = rsp_fault_r;
    assign rsp_rdata = rsp_rdata_r;

    // Request decode: offset, size, range, legality and alignment.
    always_comb begin
        off_s      = req_addr - BASE_ADDR;
        size_s     = size_of(req_funct3);
        be8_s      = gen_be(size_s, off_s[1:0]);
        // 33 bits so an offset near 2**32 cannot wrap back into range.
        end_s      = {1'b0, off_s} + {31'b0, span_m1(size_s)};
        in_range_s = ((end_s >> ADDR_WIDTH) == 33'd0);
        legal_s    = is_legal(req_we, req_funct3);
        misalign_s = ((size_s == SZ_HALF) && off_s[0]) ||
                     ((size_s == SZ_WORD) && (off_s[1:0] != 2'b00));
        idx_s      = off_s[ADDR_WIDTH-1:2];
`ifdef DMEM_MISALIGN_SPLIT_EN
        fault_s      = ~legal_s | ~in_range_s;
        split_s      = misalign_s & ~fault_s;
        wide_wdata_s = {32'h0000_0000, req_wdata} << {off_s[1:0], 3'b000};
`else
        // Any enable in the upper word means a word crossing, which is
        // already misaligned; folding it in keeps the whole enable vector live.
        fault_s = ~legal_s | ~in_range_s | misalign_s | (|be8_s[7:4]);
`endif
    end

    // Write port: accept-edge store, or upper half of a split store in SECOND.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_idx_s  = idx_s;
        wr_be_s   = 4'h0;
        wr_data_s = 32'h0000_0000;
`ifdef DMEM_MISALIGN_SPLIT_EN
        if (state_r == SECOND) begin
            wr_en_s   = sp_we_r & ~rst;
            wr_idx_s  = hi_idx_s;
            wr_be_s   = sp_be_hi_r;
            wr_data_s = sp_data_hi_r;
        end else if (accept_s && req_we && !fault_s) begin
            wr_en_s   = 1'b1;
            wr_be_s   = be8_s[3:0];
            wr_data_s = wide_wdata_s[31:0];
        end else begin
            wr_en_s   = 1'b0;
        end
`else
        if (accept_s && req_we && !fault_s) begin
            wr_en_s   = 1'b1;
            wr_be_s   = be8_s[3:0];
            wr_data_s = req_wdata << {off_s[1:0], 3'b000};
        end else begin
            wr_en_s   = 1'b0;
        end
`endif
    end

    // Byte-enabled array write; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be_s[b]) begin
                    mem_r[wr_idx_s][8*b +: 8] <= wr_data_s[8*b +: 8];
                end
            end
        end
    end

    // Pipeline entry for this edge: plain access on accept, or split completion in SECOND.
    always_comb begin
        push_s = '0;
`ifdef DMEM_MISALIGN_SPLIT_EN
        if (state_r == SECOND) begin
            push_s.valid  = 1'b1;
            push_s.fault  = 1'b0;
            push_s.we     = sp_we_r;
            push_s.funct3 = sp_funct3_r;
            push_s.off    = sp_off_r;
            push_s.data   = {mem_r[hi_idx_s], sp_lo_r};
        end else if (accept_s && !split_s) begin
`else
        if (accept_s) begin
`endif
            push_s.valid  = 1'b1;
            push_s.fault  = fault_s;
            push_s.we     = req_we;
            push_s.funct3 = req_funct3;
            push_s.off    = off_s[1:0];
            push_s.data   = {32'h0000_0000, fault_s ? 32'h0000_0000 : mem_r[idx_s]};
        end else begin
            push_s.valid  = 1'b0;
        end
    end

    // Control FSM: IDLE accepts requests, SECOND finishes a split access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            ready_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
`ifdef DMEM_MISALIGN_SPLIT_EN
                    if (accept_s && split_s) begin
                        state_r      <= SECOND;
                        ready_r      <= 1'b0;
                        sp_we_r      <= req_we;
                        sp_idx_r     <= idx_s;
                        sp_be_hi_r   <= be8_s[7:4];
                        sp_data_hi_r <= wide_wdata_s[63:32];
                        sp_lo_r      <= mem_r[idx_s];
                        sp_funct3_r  <= req_funct3;
                        sp_off_r     <= off_s[1:0];
                    end else begin
                        state_r <= IDLE;
                        ready_r <= 1'b1;
                    end
`else
                    state_r <= IDLE;
                    ready_r <= 1'b1;
`endif
                end
                SECOND: begin
                    state_r <= IDLE;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign last_s = pipe_r[RD_LATENCY-1];

    dmem_load_align u_align (
        .funct3 (last_s.funct3),
        .off    (last_s.off),
        .data   (last_s.data),
        .rdata  (align_s)
    );

    // Response pipeline and registered response outputs; reset drops in-flight entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_r[i] <= '0;
            end
            rsp_valid_r <= 1'b0;
            rsp_fault_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
        end else begin
            pipe_r[0] <= push_s;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
            rsp_valid_r <= last_s.valid;
            rsp_fault_r <= last_s.valid & last_s.fault;
            rsp_rdata_r <= (last_s.valid && !last_s.fault && !last_s.we) ? align_s : 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_data_memory_lsu.sv
module tb_data_memory_lsu;

`ifdef DMEM_MISALIGN_SPLIT_EN
    localparam int SPLIT = 1;
`else
    localparam int SPLIT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rdy1, rdy3, v1, v3, f1, f3o;
    logic [31:0] d1, d3;

    int total = 0;
    int bad   = 0;

    logic [31:0] bb_exp [4];

    always #5 clk = ~clk;

    data_memory_lsu #(.ADDR_WIDTH(16), .BASE_ADDR(32'h0000_0000), .RD_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(v1), .rsp_rdata(d1), .rsp_fault(f1)
    );

    data_memory_lsu #(.ADDR_WIDTH(16), .BASE_ADDR(32'h0000_0000), .RD_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy3), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(v3), .rsp_rdata(d3), .rsp_fault(f3o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One request, then watch both DUTs until both responses have been seen.
    task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_d, input logic exp_f, input int extra);
        @(negedge clk);
        check({tag, ".rdy"}, 32'(rdy1 & rdy3), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (extra != 0) check({tag, ".busy"}, 32'(rdy1 | rdy3), 32'd0);
        for (int c = 1; c <= 3 + extra; c++) begin
            @(posedge clk);
            #1;
            if (c == 1 + extra) begin
                check({tag, ".v1"}, 32'(v1), 32'd1);
                check({tag, ".d1"}, d1, exp_d);
                check({tag, ".f1"}, 32'(f1), 32'(exp_f));
            end else begin
                check({tag, ".v1idle"}, 32'(v1), 32'd0);
            end
            if (c == 3 + extra) begin
                check({tag, ".v3"}, 32'(v3), 32'd1);
                check({tag, ".d3"}, d3, exp_d);
                check({tag, ".f3"}, 32'(f3o), 32'(exp_f));
            end else begin
                check({tag, ".v3idle"}, 32'(v3), 32'd0);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        bb_exp[0]  = 32'h0000_0000;
        bb_exp[1]  = 32'h0000_005A;
        bb_exp[2]  = 32'hFFFF_80AD;
        bb_exp[3]  = 32'h0000_80AD;

        repeat (3) @(posedge clk);
        #1;
        check("rst.v", 32'({v1, v3, f1, f3o}), 32'd0);
        check("rst.d1", d1, 32'h0);
        check("rst.d3", d3, 32'h0);
        check("rst.rdy", 32'(rdy1 | rdy3), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("sw100",  1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
        run_op("lw100",  1'b0, 3'd2, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
        run_op("sw104",  1'b1, 3'd2, 32'h104, 32'h0000_00EF, 32'h0, 1'b0, 0);
        run_op("sw0",    1'b1, 3'd2, 32'h000, 32'h0102_0304, 32'h0, 1'b0, 0);
        run_op("sb103",  1'b1, 3'd0, 32'h103, 32'h1234_5680, 32'h0, 1'b0, 0);
        run_op("lb103",  1'b0, 3'd0, 32'h103, 32'h0, 32'hFFFF_FF80, 1'b0, 0);
        run_op("lbu103", 1'b0, 3'd4, 32'h103, 32'h0, 32'h0000_0080, 1'b0, 0);
        run_op("lw100b", 1'b0, 3'd2, 32'h100, 32'h0, 32'h80AD_BEEF, 1'b0, 0);

        // Back-to-back: SB then dependent LBU, then LH/LHU, one accept per cycle.
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            req_valid = (c < 4);
            case (c)
                0: begin req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h105; req_wdata = 32'hAAAA_AA5A; end
                1: begin req_we = 1'b0; req_funct3 = 3'd4; req_addr = 32'h105; req_wdata = 32'h0; end
                2: begin req_we = 1'b0; req_funct3 = 3'd1; req_addr = 32'h102; end
                3: begin req_we = 1'b0; req_funct3 = 3'd5; req_addr = 32'h102; end
                default: begin req_we = 1'b0; end
            endcase
            @(posedge clk);
            #1;
            if (c >= 1 && c <= 4) begin
                check("b2b.v1", 32'(v1), 32'd1);
                check("b2b.d1", d1, bb_exp[c-1]);
            end else begin
                check("b2b.v1idle", 32'(v1), 32'd0);
            end
            if (c >= 3 && c <= 6) begin
                check("b2b.v3", 32'(v3), 32'd1);
                check("b2b.d3", d3, bb_exp[c-3]);
            end else begin
                check("b2b.v3idle", 32'(v3), 32'd0);
            end
        end
        req_valid = 1'b0;

        // Misaligned word accesses.
        run_op("lw101",  1'b0, 3'd2, 32'h101, 32'h0, (SPLIT != 0) ? 32'hEF80_ADBE : 32'h0,
               (SPLIT != 0) ? 1'b0 : 1'b1, SPLIT);
        run_op("sw101",  1'b1, 3'd2, 32'h101, 32'h1122_3344, 32'h0, (SPLIT != 0) ? 1'b0 : 1'b1, SPLIT);
        run_op("lw101b", 1'b0, 3'd2, 32'h101, 32'h0, (SPLIT != 0) ? 32'h1122_3344 : 32'h0,
               (SPLIT != 0) ? 1'b0 : 1'b1, SPLIT);
        run_op("lw100c", 1'b0, 3'd2, 32'h100, 32'h0, (SPLIT != 0) ? 32'h2233_44EF : 32'h80AD_BEEF, 1'b0, 0);
        run_op("sh106",  1'b1, 3'd1, 32'h106, 32'hBEEF_1234, 32'h0, 1'b0, 0);
        run_op("lw104",  1'b0, 3'd2, 32'h104, 32'h0, (SPLIT != 0) ? 32'h1234_5A11 : 32'h1234_5AEF, 1'b0, 0);

        // Faulting accesses, then re-read to confirm nothing was written.
        run_op("lwoor",  1'b0, 3'd2, 32'h1_0000, 32'h0, 32'h0, 1'b1, 0);
        run_op("swoor",  1'b1, 3'd2, 32'h1_0000, 32'hCAFE_F00D, 32'h0, 1'b1, 0);
        run_op("ld_f3",  1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 1'b1, 0);
        run_op("st_f4",  1'b1, 3'd4, 32'h100, 32'h5555_5555, 32'h0, 1'b1, 0);
        run_op("lw0",    1'b0, 3'd2, 32'h000, 32'h0, 32'h0102_0304, 1'b0, 0);
        run_op("lw100d", 1'b0, 3'd2, 32'h100, 32'h0, (SPLIT != 0) ? 32'h2233_44EF : 32'h80AD_BEEF, 1'b0, 0);

        // Top-of-array boundary.
        run_op("swtop",  1'b1, 3'd2, 32'hFFFC, 32'hA5A5_5A5A, 32'h0, 1'b0, 0);
        run_op("lwtop",  1'b0, 3'd2, 32'hFFFC, 32'h0, 32'hA5A5_5A5A, 1'b0, 0);
        run_op("lbtop",  1'b0, 3'd0, 32'hFFFF, 32'h0, 32'hFFFF_FFA5, 1'b0, 0);
        run_op("lhx",    1'b0, 3'd1, 32'hFFFF, 32'h0, 32'h0, 1'b1, 0);
        run_op("lwx",    1'b0, 3'd2, 32'hFFFE, 32'h0, 32'h0, 1'b1, 0);

        // Reset with two loads in flight: none of them may respond afterwards.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'd2;
        req_addr   = 32'h100;
        @(posedge clk);
        @(negedge clk);
        req_addr = 32'h104;
        @(posedge clk);
        #1;
        check("rst2.pre", 32'(v1), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        check("rst2.v", 32'(v1 | v3), 32'd0);
        check("rst2.rdy", 32'(rdy1 | rdy3), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            check("rst2.drop", 32'(v1 | v3), 32'd0);
            check("rst2.rdyup", 32'(rdy1 & rdy3), 32'd1);
        end
        run_op("lw100e", 1'b0, 3'd2, 32'h100, 32'h0, (SPLIT != 0) ? 32'h2233_44EF : 32'h80AD_BEEF, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
